// File: rtl/pipe_reg_exmem_gen_if.sv
// EX->MEM bundle for the generalised EX/MEM pipeline register.
// The EX side drives master; the register itself connects as slave.
interface pipe_reg_exmem_gen_if #(
  parameter int DATA_LEN    = 32,
  parameter int REG_SIZE    = 5,
  parameter int CTRL_W      = 4,
  parameter int STALL_CNT_W = 8
);
  logic                   valid_i;
  logic [CTRL_W-1:0]      ctrl_i;
  logic [REG_SIZE-1:0]    rd_i;
  logic [DATA_LEN-1:0]    MuxResult_i;
  logic [DATA_LEN-1:0]    ALUResult_i;
  logic                   Data_Stall_i;
  logic                   flush_i;

  logic                   valid_o;
  logic [CTRL_W-1:0]      ctrl_o;
  logic [REG_SIZE-1:0]    rd_o;
  logic [DATA_LEN-1:0]    MuxResult_o;
  logic [DATA_LEN-1:0]    ALUResult_o;
  logic [2:0]             occupancy_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output valid_i, ctrl_i, rd_i, MuxResult_i, ALUResult_i, Data_Stall_i, flush_i,
    input  valid_o, ctrl_o, rd_o, MuxResult_o, ALUResult_o, occupancy_o, stall_cnt_o
  );

  modport slave (
    input  valid_i, ctrl_i, rd_i, MuxResult_i, ALUResult_i, Data_Stall_i, flush_i,
    output valid_o, ctrl_o, rd_o, MuxResult_o, ALUResult_o, occupancy_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_reg_exmem_gen.sv
// Parametrised EX/MEM pipeline register: DEPTH chained stages with valid bits,
// stall hold, flush/bubble insertion and a saturating consecutive-stall counter.
module pipe_reg_exmem_gen #(
  parameter int DATA_LEN    = 32,
  parameter int REG_SIZE    = 5,
  parameter int CTRL_W      = 4,
  parameter int DEPTH       = 1,
  parameter int STALL_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipe_reg_exmem_gen_if.slave  bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : gDepthCheck
    $error("pipe_reg_exmem_gen: DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic [REG_SIZE-1:0] rd;
    logic [DATA_LEN-1:0] mux;
    logic [DATA_LEN-1:0] alu;
  } payload_t;

  logic [DEPTH-1:0]       stageValid;
  logic [CTRL_W-1:0]      stageCtrl [DEPTH];
  payload_t               stagePay  [DEPTH];
  logic [DEPTH-1:0]       nextValid;
  logic [2:0]             occupancy;
  logic [STALL_CNT_W-1:0] stallCnt;

  logic advance;
  assign advance = !bus.flush_i && !bus.Data_Stall_i;

  // Valid vector after the coming edge; occupancy is registered from it so it
  // tracks the stages on the same edge.
  always_comb begin
    // NOTE: defaulting every always_comb output first means no path can leave it unassigned, so no latch is inferred.
    nextValid = stageValid;
    if (bus.flush_i) begin
      nextValid = '0;
    end else if (!bus.Data_Stall_i) begin
      nextValid[0] = bus.valid_i;
      for (int k = 1; k < DEPTH; k++) nextValid[k] = stageValid[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state uses non-blocking assignments so every stage reads its neighbour's pre-edge value.
    if (rst_i) begin
      stageValid <= '0;
      occupancy  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stageCtrl[k] <= '0;
        stagePay[k]  <= '0;
      end
    end else begin
      stageValid <= nextValid;
      occupancy  <= 3'($countones(nextValid));
      if (bus.flush_i) begin
        // Flush only kills valid and ctrl; rd/data keep their contents.
        for (int k = 0; k < DEPTH; k++) stageCtrl[k] <= '0;
      end else if (advance) begin
        stageCtrl[0] <= bus.valid_i ? bus.ctrl_i : '0;
        stagePay[0]  <= '{rd: bus.rd_i, mux: bus.MuxResult_i, alu: bus.ALUResult_i};
        for (int k = 1; k < DEPTH; k++) begin
          stageCtrl[k] <= stageCtrl[k-1];
          stagePay[k]  <= stagePay[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCnt <= '0;
    end else if (bus.Data_Stall_i && !bus.flush_i) begin
      if (stallCnt != '1) stallCnt <= stallCnt + STALL_CNT_W'(1);
    end else begin
      stallCnt <= '0;
    end
  end

  assign bus.valid_o     = stageValid[DEPTH-1];
  assign bus.ctrl_o      = stageCtrl[DEPTH-1] & {CTRL_W{stageValid[DEPTH-1]}};
  assign bus.rd_o        = stagePay[DEPTH-1].rd;
  assign bus.MuxResult_o = stagePay[DEPTH-1].mux;
  assign bus.ALUResult_o = stagePay[DEPTH-1].alu;
  assign bus.occupancy_o = occupancy;
  assign bus.stall_cnt_o = stallCnt;

endmodule

// File: tb/tb_pipe_reg_exmem_gen.sv
// Bench for pipe_reg_exmem_gen: four configurations share one stimulus stream
// and are compared every cycle against a queue-based model.
module tb_pipe_reg_exmem_gen;

  localparam int NINST = 4;

  function automatic int depthOf(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int swOf(int i);
    return (i == 3) ? 2 : 8;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [3:0]  inCtrl;
  logic [4:0]  inRd;
  logic [31:0] inMux;
  logic [31:0] inAlu;
  logic        inStall;
  logic        inFlush;

  always #5 clk = ~clk;

  wire        oValid [NINST];
  wire [3:0]  oCtrl  [NINST];
  wire [4:0]  oRd    [NINST];
  wire [31:0] oMux   [NINST];
  wire [31:0] oAlu   [NINST];
  wire [2:0]  oOcc   [NINST];
  wire [7:0]  oStall [NINST];

  for (genvar g = 0; g < NINST; g++) begin : gInst
    localparam int D = depthOf(g);
    localparam int W = swOf(g);

    pipe_reg_exmem_gen_if #(.STALL_CNT_W(W)) bus ();

    assign bus.valid_i      = inValid;
    assign bus.ctrl_i       = inCtrl;
    assign bus.rd_i         = inRd;
    assign bus.MuxResult_i  = inMux;
    assign bus.ALUResult_i  = inAlu;
    assign bus.Data_Stall_i = inStall;
    assign bus.flush_i      = inFlush;

    pipe_reg_exmem_gen #(.DEPTH(D), .STALL_CNT_W(W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );

    assign oValid[g] = bus.valid_o;
    assign oCtrl[g]  = bus.ctrl_o;
    assign oRd[g]    = bus.rd_o;
    assign oMux[g]   = bus.MuxResult_o;
    assign oAlu[g]   = bus.ALUResult_o;
    assign oOcc[g]   = bus.occupancy_o;
    assign oStall[g] = 8'(bus.stall_cnt_o);
  end

  // Model: each configuration is a queue of in-flight slots, newest at the front.
  typedef struct packed {
    logic        v;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] mux;
    logic [31:0] alu;
  } entry_t;

  entry_t pipe [NINST][$];
  int     stallRun [NINST];

  int nCompared   = 0;
  int nMismatched = 0;
  bit checkEn     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NINST; i++) begin
      pipe[i].delete();
      for (int k = 0; k < depthOf(i); k++) pipe[i].push_back('0);
      stallRun[i] = 0;
    end
  endtask

  task automatic modelStep();
    entry_t e;
    for (int i = 0; i < NINST; i++) begin
      if (inFlush) begin
        for (int k = 0; k < pipe[i].size(); k++) begin
          e = pipe[i][k];
          e.v = 1'b0;
          e.ctrl = '0;
          pipe[i][k] = e;
        end
        stallRun[i] = 0;
      end else if (inStall) begin
        if (stallRun[i] < (1 << swOf(i)) - 1) stallRun[i]++;
      end else begin
        e = '{v: inValid, ctrl: inCtrl, rd: inRd, mux: inMux, alu: inAlu};
        pipe[i].push_front(e);
        void'(pipe[i].pop_back());
        stallRun[i] = 0;
      end
    end
  endtask

  task automatic compareInst(input int i);
    entry_t last;
    int occ;
    last = pipe[i][depthOf(i)-1];
    occ = 0;
    for (int k = 0; k < pipe[i].size(); k++) if (pipe[i][k].v) occ++;
    check($sformatf("valid_o[%0d]", i), 32'(oValid[i]), 32'(last.v));
    check($sformatf("ctrl_o[%0d]", i),  32'(oCtrl[i]),  last.v ? 32'(last.ctrl) : 32'd0);
    check($sformatf("rd_o[%0d]", i),    32'(oRd[i]),    32'(last.rd));
    check($sformatf("mux_o[%0d]", i),   oMux[i],        last.mux);
    check($sformatf("alu_o[%0d]", i),   oAlu[i],        last.alu);
    check($sformatf("occ_o[%0d]", i),   32'(oOcc[i]),   32'(occ));
    check($sformatf("stall_o[%0d]", i), 32'(oStall[i]), 32'(stallRun[i]));
  endtask

  always @(negedge clk) begin
    if (checkEn) for (int i = 0; i < NINST; i++) compareInst(i);
  end

  task automatic tick();
    @(posedge clk);
    if (rst) modelReset();
    else modelStep();
    #1;
  endtask

  task automatic setOp(input logic v, input logic [3:0] c, input logic [4:0] r,
                       input logic [31:0] m, input logic [31:0] a);
    inValid = v; inCtrl = c; inRd = r; inMux = m; inAlu = a;
  endtask

  initial begin
    rst = 1'b1;
    inStall = 1'b0;
    inFlush = 1'b0;
    setOp(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
    modelReset();
    checkEn = 1'b1;

    tick();
    check("reset_valid", 32'(oValid[2]), 32'd0);
    check("reset_occ",   32'(oOcc[2]),   32'd0);
    check("reset_stall", 32'(oStall[1]), 32'd0);
    tick();
    rst = 1'b0;

    // Back-to-back ops: DEPTH=3 latency and occupancy ramp.
    setOp(1'b1, 4'b0001, 5'd1, 32'h0, 32'hA);
    tick();
    check("d3_occ1", 32'(oOcc[2]), 32'd1);
    check("d1_aluA", oAlu[0], 32'hA);
    setOp(1'b1, 4'b0001, 5'd2, 32'h0, 32'hB);
    tick();
    check("d3_occ2", 32'(oOcc[2]), 32'd2);
    setOp(1'b1, 4'b0001, 5'd3, 32'h0, 32'hC);
    tick();
    check("d3_occ3", 32'(oOcc[2]), 32'd3);
    check("d3_aluA", oAlu[2], 32'hA);

    // DEPTH=1 passthrough.
    setOp(1'b1, 4'b0001, 5'd5, 32'h0, 32'h1234);
    tick();
    check("d1_valid", 32'(oValid[0]), 32'd1);
    check("d1_ctrl",  32'(oCtrl[0]),  32'h1);
    check("d1_rd",    32'(oRd[0]),    32'd5);
    check("d1_alu",   oAlu[0],        32'h1234);
    check("d2_aluC",  oAlu[1],        32'hC);

    // Five-cycle stall: DEPTH=2 frozen, counters run, 2-bit counter saturates.
    inStall = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      setOp(1'($urandom), 4'($urandom), 5'($urandom), $urandom, $urandom);
      tick();
      check("stall_cnt",   32'(oStall[1]), 32'(s));
      check("stall_alu",   oAlu[1],        32'hC);
      check("stall_occ",   32'(oOcc[1]),   32'd2);
      check("stall_sat",   32'(oStall[3]), (s > 3) ? 32'd3 : 32'(s));
    end
    inStall = 1'b0;
    setOp(1'b1, 4'b0101, 5'd7, 32'h0, 32'h77);
    tick();
    check("release_cnt", 32'(oStall[1]), 32'd0);
    check("release_alu", oAlu[1],        32'h1234);
    setOp(1'b1, 4'b0101, 5'd8, 32'h0, 32'h88);
    tick();
    check("full_ctrl", 32'(oCtrl[1]), 32'h5);
    check("full_alu",  oAlu[1],       32'h77);

    // Flush together with stall: flush wins, data retained.
    inStall = 1'b1;
    inFlush = 1'b1;
    tick();
    check("flush_valid", 32'(oValid[1]), 32'd0);
    check("flush_ctrl",  32'(oCtrl[1]),  32'd0);
    check("flush_occ",   32'(oOcc[1]),   32'd0);
    check("flush_stall", 32'(oStall[1]), 32'd0);
    check("flush_alu",   oAlu[1],        32'h77);
    inStall = 1'b0;
    inFlush = 1'b0;

    // Bubble carrying all-ones ctrl.
    setOp(1'b0, 4'b1111, 5'd9, 32'h0, 32'h99);
    tick();
    check("bubble_valid", 32'(oValid[0]), 32'd0);
    check("bubble_ctrl",  32'(oCtrl[0]),  32'd0);
    check("bubble_occ0",  32'(oOcc[0]),   32'd0);
    check("bubble_occ1",  32'(oOcc[1]),   32'd0);

    // Fill, stall, then assert reset between edges.
    for (int n = 0; n < 3; n++) begin
      setOp(1'b1, 4'($urandom), 5'($urandom), $urandom, $urandom | 32'h1);
      tick();
    end
    inStall = 1'b1;
    tick();
    tick();
    check("pre_rst_occ",   32'(oOcc[2]),   32'd3);
    check("pre_rst_stall", 32'(oStall[1]), 32'd2);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    for (int i = 0; i < NINST; i++) begin
      check($sformatf("async_rst_valid[%0d]", i), 32'(oValid[i]), 32'd0);
      check($sformatf("async_rst_ctrl[%0d]", i),  32'(oCtrl[i]),  32'd0);
      check($sformatf("async_rst_rd[%0d]", i),    32'(oRd[i]),    32'd0);
      check($sformatf("async_rst_alu[%0d]", i),   oAlu[i],        32'd0);
      check($sformatf("async_rst_mux[%0d]", i),   oMux[i],        32'd0);
      check($sformatf("async_rst_occ[%0d]", i),   32'(oOcc[i]),   32'd0);
      check($sformatf("async_rst_stall[%0d]", i), 32'(oStall[i]), 32'd0);
    end
    inStall = 1'b0;
    tick();
    rst = 1'b0;

    // Randomised traffic with occasional stall runs and flushes.
    for (int n = 0; n < 3000; n++) begin
      setOp(1'($urandom), 4'($urandom), 5'($urandom), $urandom, $urandom);
      inStall = ($urandom_range(0, 3) == 0);
      inFlush = ($urandom_range(0, 11) == 0);
      tick();
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
